fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_sequencer_if.sv | 24 ++
 rtl/fetch_opdec.sv | 26 ++
 rtl/fetch_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, opcodes and state encoding for the fetch sequencer
package fetch_pkg;

  localparam int W    = 10;
  localparam int OP_W = 4;

  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_TGT   = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - sequencer to fetch-unit PC control bus
interface fetch_sequencer_if #(
  parameter int W = 10
);

  logic         en;
  logic         ctrl;
  logic         cin;
  logic [W-1:0] la;
  logic [W-1:0] val1;
  logic [W-1:0] instr;
  logic         cout;

  modport master (
    output en, ctrl, cin, la, val1,
    input  instr, cout
  );

  modport slave (
    input  en, ctrl, cin, la, val1,
    output instr, cout
  );

endinterface

// File: rtl/fetch_opdec.sv
// rtl/fetch_opdec.sv - combinational opcode classifier and branch offset sign-extender
module fetch_opdec #(
  parameter int W    = fetch_pkg::W,
  parameter int OP_W = fetch_pkg::OP_W
) (
  input  logic [W-1:0] instr,
  output logic         is_jmp,
  output logic         is_beq,
  output logic         is_halt,
  output logic [W-1:0] sext_off
);

  import fetch_pkg::*;

  logic [OP_W-1:0] opcode;

  // Opcode sits in the top bits; the 6-bit branch offset in the bottom bits.
  always_comb begin
    opcode   = instr[W-1 -: OP_W];
    is_jmp   = (opcode == OP_W'(OP_JMP));
    is_beq   = (opcode == OP_W'(OP_BEQ));
    is_halt  = (opcode == OP_W'(OP_HALT));
    sext_off = {{(W-6){instr[5]}}, instr[5:0]};
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch FSM steering the PC adder/mux and issuing instructions
module fetch_sequencer #(
  parameter int W    = fetch_pkg::W,
  parameter int OP_W = fetch_pkg::OP_W
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.master   fu,
  input  logic                zflag,
  input  logic                stall,
  output logic [W-1:0]        ir,
  output logic                ir_valid,
  output logic                halted,
  output logic                wrap_err
);

  import fetch_pkg::*;

  localparam logic [1:0] S_RST   = ST_RST;
  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_TGT   = ST_TGT;
  localparam logic [1:0] S_HALT  = ST_HALT;

  logic [1:0]   state_q,    state_d;
  logic [W-1:0] ir_q,       ir_d;
  logic         ir_valid_q, ir_valid_d;
  logic         halted_q,   halted_d;
  logic         wrap_err_q, wrap_err_d;

  logic         en_c;
  logic         ctrl_c;
  logic [W-1:0] la_c;
  logic [W-1:0] val1_c;

  logic         is_jmp;
  logic         is_beq;
  logic         is_halt;
  logic [W-1:0] sext_off;

  fetch_opdec #(
    .W    (W),
    .OP_W (OP_W)
  ) u_opdec (
    .instr    (fu.instr),
    .is_jmp   (is_jmp),
    .is_beq   (is_beq),
    .is_halt  (is_halt),
    .sext_off (sext_off)
  );

  // Next-state and PC-control decode; stall freezes everything and drops ir_valid.
  always_comb begin
    en_c       = 1'b0;
    ctrl_c     = 1'b0;
    la_c       = '0;
    val1_c     = W'(1);
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    halted_d   = halted_q;
    wrap_err_d = wrap_err_q;

    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!stall) begin
          ir_d       = fu.instr;
          ir_valid_d = 1'b1;
          if (is_halt) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            en_c = 1'b1;
            if (is_jmp) begin
              state_d = S_TGT;
            end else if (is_beq && zflag) begin
              val1_c = sext_off;
            end
          end
        end
      end
      S_TGT: begin
        // The word after a JMP is the absolute target, not an instruction.
        if (!stall) begin
          en_c    = 1'b1;
          ctrl_c  = 1'b1;
          la_c    = fu.instr;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
      end
      default: begin
        state_d = S_RST;
      end
    endcase

    if (en_c && !ctrl_c && fu.cout) begin
      wrap_err_d = 1'b1;
    end
  end

  // Drive the fetch-unit bus from the decoded controls.
  always_comb begin
    fu.en   = en_c;
    fu.ctrl = ctrl_c;
    fu.cin  = 1'b0;
    fu.la   = la_c;
    fu.val1 = val1_c;
  end

  // State registers with synchronous reset taking priority over stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RST;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      wrap_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      wrap_err_q <= wrap_err_d;
    end
  end

  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;
  assign wrap_err = wrap_err_q;

endmodule
